// File: rtl/lane_judge.sv
// Rhythm-game lane judge: per-lane falling notes advanced by tick, judged on key
// press against a hit zone, with score, combo, life and game-over bookkeeping.
module lane_judge #(
  parameter int LANES    = 4,
  parameter int POS_W    = 4,
  parameter int HIT_POS  = 12,
  parameter int GOOD_WIN = 1,
  parameter int LIFE_MAX = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [LANES-1:0]       spawn,
  input  logic [LANES-1:0]       key,
  output logic [LANES*POS_W-1:0] pos,
  output logic [LANES-1:0]       active,
  output logic                   hit,
  output logic                   perfect,
  output logic                   damage,
  output logic [7:0]             combo,
  output logic [13:0]            score,
  output logic [LIFE_MAX-1:0]    life,
  output logic                   game_over
);

  localparam logic [POS_W-1:0] LP_POS_MAX = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] LP_HIT     = POS_W'(HIT_POS);
  localparam logic [POS_W-1:0] LP_WIN     = POS_W'(GOOD_WIN);
  localparam logic [14:0]      LP_SCORE_MAX = 15'd9999;

  logic [LANES-1:0][POS_W-1:0] r_pos;
  logic [LANES-1:0]            r_act;
  logic                        r_hit;
  logic                        r_perfect;
  logic                        r_damage;
  logic [7:0]                  r_combo;
  logic [13:0]                 r_score;
  logic [LIFE_MAX-1:0]         r_life;
  logic                        r_game_over;

  logic [LANES-1:0][POS_W-1:0] w_pos_nxt;
  logic [LANES-1:0]            w_act_nxt;
  logic [3:0]                  w_hits;
  logic [3:0]                  w_exp_cnt;
  logic [4:0]                  w_award;
  logic                        w_any_perf;
  logic                        w_miss;
  logic [14:0]                 w_score_sum;
  logic [8:0]                  w_combo_sum;
  logic [LIFE_MAX-1:0]         w_life_nxt;

  // Per-lane next state. A successful judgement takes priority over tick, so a
  // lane hit on a tick cycle is cleared instead of advancing or expiring.
  always_comb begin
    logic [POS_W-1:0] v_dist;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_pos_nxt  = r_pos;
    w_act_nxt  = r_act;
    w_hits     = '0;
    w_exp_cnt  = '0;
    w_award    = '0;
    w_any_perf = 1'b0;
    w_miss     = 1'b0;
    v_dist     = '0;
    for (int i = 0; i < LANES; i++) begin
      v_dist = (r_pos[i] >= LP_HIT) ? (r_pos[i] - LP_HIT) : (LP_HIT - r_pos[i]);
      if (key[i] && r_act[i] && (v_dist <= LP_WIN)) begin
        w_act_nxt[i] = 1'b0;
        w_pos_nxt[i] = '0;
        w_hits       = w_hits + 4'd1;
        if (v_dist == '0) begin
          w_award    = w_award + 5'd2;
          w_any_perf = 1'b1;
        end else begin
          w_award    = w_award + 5'd1;
        end
      end else begin
        // An off-beat press only breaks the combo; tick still applies to the lane.
        if (key[i] && r_act[i]) w_miss = 1'b1;
        if (tick) begin
          if (r_act[i]) begin
            if (r_pos[i] == LP_POS_MAX) begin
              w_exp_cnt    = w_exp_cnt + 4'd1;
              w_miss       = 1'b1;
              w_act_nxt[i] = spawn[i];
              w_pos_nxt[i] = '0;
            end else begin
              w_pos_nxt[i] = r_pos[i] + 1'b1;
            end
          end else if (spawn[i]) begin
            w_act_nxt[i] = 1'b1;
            w_pos_nxt[i] = '0;
          end
        end
      end
    end
  end

  assign w_score_sum = {1'b0, r_score} + {10'd0, w_award};
  assign w_combo_sum = {1'b0, r_combo} + {5'd0, w_hits};
  // Life is a thermometer, so losing n units is a right shift that bottoms out at 0.
  assign w_life_nxt  = r_life >> w_exp_cnt;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos       <= '0;
      r_act       <= '0;
      r_hit       <= 1'b0;
      r_perfect   <= 1'b0;
      r_damage    <= 1'b0;
      r_combo     <= '0;
      r_score     <= '0;
      r_life      <= '1;
      r_game_over <= 1'b0;
    end else if (!r_game_over) begin
      r_pos       <= w_pos_nxt;
      r_act       <= w_act_nxt;
      r_hit       <= (w_hits != '0);
      r_perfect   <= w_any_perf;
      r_damage    <= (w_exp_cnt != '0);
      r_score     <= (w_score_sum > LP_SCORE_MAX) ? LP_SCORE_MAX[13:0] : w_score_sum[13:0];
      if (w_miss)
        r_combo   <= '0;
      else
        r_combo   <= w_combo_sum[8] ? 8'd255 : w_combo_sum[7:0];
      r_life      <= w_life_nxt;
      r_game_over <= ~w_life_nxt[0];
    end else begin
      r_hit       <= 1'b0;
      r_perfect   <= 1'b0;
      r_damage    <= 1'b0;
    end
  end

  assign pos       = r_pos;
  assign active    = r_act;
  assign hit       = r_hit;
  assign perfect   = r_perfect;
  assign damage    = r_damage;
  assign combo     = r_combo;
  assign score     = r_score;
  assign life      = r_life;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_lane_judge.sv
// Scoreboard bench for lane_judge: a lane-level reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_lane_judge;

  localparam int LANES    = 4;
  localparam int POS_W    = 4;
  localparam int HIT_POS  = 12;
  localparam int GOOD_WIN = 1;
  localparam int LIFE_MAX = 10;
  localparam int POS_MAX  = (1 << POS_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   tick = 1'b0;
  logic [LANES-1:0]       spawn = '0;
  logic [LANES-1:0]       key = '0;
  logic [LANES*POS_W-1:0] pos;
  logic [LANES-1:0]       active;
  logic                   hit, perfect, damage, game_over;
  logic [7:0]             combo;
  logic [13:0]            score;
  logic [LIFE_MAX-1:0]    life;

  lane_judge #(
    .LANES(LANES), .POS_W(POS_W), .HIT_POS(HIT_POS), .GOOD_WIN(GOOD_WIN), .LIFE_MAX(LIFE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .spawn(spawn), .key(key),
    .pos(pos), .active(active), .hit(hit), .perfect(perfect), .damage(damage),
    .combo(combo), .score(score), .life(life), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*POS_W-1:0] pos;
    logic [LANES-1:0]       active;
    logic                   hit;
    logic                   perfect;
    logic                   damage;
    logic [7:0]             combo;
    logic [13:0]            score;
    logic [LIFE_MAX-1:0]    life;
    logic                   game_over;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain integers per lane and per counter.
  int m_act[LANES];
  int m_pos[LANES];
  int m_score, m_combo, m_life;
  bit m_go;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input logic [LANES-1:0] sp,
                            input logic [LANES-1:0] k, output exp_t e);
    int hits, perfs, expired, award, d;
    bit miss;
    hits = 0; perfs = 0; expired = 0; award = 0; miss = 0;
    if (r) begin
      for (int i = 0; i < LANES; i++) begin m_act[i] = 0; m_pos[i] = 0; end
      m_score = 0; m_combo = 0; m_life = LIFE_MAX; m_go = 0;
    end else if (!m_go) begin
      for (int i = 0; i < LANES; i++) begin
        d = m_pos[i] - HIT_POS;
        if (d < 0) d = -d;
        if (k[i] && m_act[i] == 1 && d <= GOOD_WIN) begin
          hits++;
          if (d == 0) begin perfs++; award += 2; end
          else award += 1;
          m_act[i] = 0; m_pos[i] = 0;
          continue;
        end
        if (k[i] && m_act[i] == 1) miss = 1;
        if (t) begin
          if (m_act[i] == 1) begin
            if (m_pos[i] == POS_MAX) begin
              expired++; miss = 1;
              m_act[i] = sp[i] ? 1 : 0; m_pos[i] = 0;
            end else m_pos[i]++;
          end else if (sp[i]) begin
            m_act[i] = 1; m_pos[i] = 0;
          end
        end
      end
      m_score = (m_score + award > 9999) ? 9999 : m_score + award;
      m_combo = miss ? 0 : ((m_combo + hits > 255) ? 255 : m_combo + hits);
      m_life  = (m_life - expired < 0) ? 0 : m_life - expired;
      m_go    = (m_life == 0);
    end
    for (int i = 0; i < LANES; i++) begin
      e.pos[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
      e.active[i]             = (m_act[i] == 1);
    end
    e.hit       = (!r && hits > 0);
    e.perfect   = (!r && perfs > 0);
    e.damage    = (!r && expired > 0);
    e.combo     = 8'(m_combo);
    e.score     = 14'(m_score);
    e.life      = '0;
    for (int j = 0; j < LIFE_MAX; j++) if (j < m_life) e.life[j] = 1'b1;
    e.game_over = m_go;
  endtask

  // Driver: apply inputs at negedge, predict at posedge, return at next negedge.
  task automatic step(input bit r, input bit t, input logic [LANES-1:0] sp, input logic [LANES-1:0] k);
    exp_t e;
    rst = r; tick = t; spawn = sp; key = k;
    @(posedge clk);
    model_step(r, t, sp, k, e);
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, '0, '0);
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("pos",       32'(pos),       32'(e.pos));
      check("active",    32'(active),    32'(e.active));
      check("hit",       32'(hit),       32'(e.hit));
      check("perfect",   32'(perfect),   32'(e.perfect));
      check("damage",    32'(damage),    32'(e.damage));
      check("combo",     32'(combo),     32'(e.combo));
      check("score",     32'(score),     32'(e.score));
      check("life",      32'(life),      32'(e.life));
      check("game_over", 32'(game_over), 32'(e.game_over));
    end
  end

  initial begin
    logic [LANES-1:0] sp, k;
    bit t, r, saw_9998;
    int d;

    step(1, 0, '0, '0);
    step(1, 1, '1, '1);
    check("rst_life", 32'(life), 32'h3FF);
    check("rst_active", 32'(active), 32'h0);

    // Perfect on lane 0 after 12 ticks.
    step(0, 1, 4'b0001, '0);
    ticks(12);
    step(0, 0, '0, 4'b0001);
    check("perf_pulse", 32'(perfect), 32'd1);
    check("perf_score", 32'(score), 32'd2);
    check("perf_combo", 32'(combo), 32'd1);
    step(0, 0, '0, '0);
    check("perf_no_stretch", 32'(perfect), 32'd0);

    // GOOD on lane 1 at pos 11, then off-beat at pos 5.
    step(0, 1, 4'b0010, '0);
    ticks(11);
    step(0, 0, '0, 4'b0010);
    check("good_hit", 32'(hit), 32'd1);
    check("good_perfect", 32'(perfect), 32'd0);
    check("good_score", 32'(score), 32'd3);
    step(0, 1, 4'b0010, '0);
    ticks(5);
    step(0, 0, '0, 4'b0010);
    check("offbeat_combo", 32'(combo), 32'd0);
    check("offbeat_active", 32'(active[1]), 32'd1);
    check("offbeat_life", 32'(life), 32'h3FF);

    // Key and tick together at the hit position.
    step(1, 0, '0, '0);
    step(0, 1, 4'b0100, '0);
    ticks(12);
    step(0, 1, '0, 4'b0100);
    check("keytick_perfect", 32'(perfect), 32'd1);
    check("keytick_active", 32'(active[2]), 32'd0);
    check("keytick_damage", 32'(damage), 32'd0);

    // All four lanes expire together.
    step(1, 0, '0, '0);
    step(0, 1, 4'b1111, '0);
    ticks(15);
    check("pre_expiry_damage", 32'(damage), 32'd0);
    ticks(1);
    check("expiry_damage", 32'(damage), 32'd1);
    check("expiry_life", 32'(life), 32'h03F);
    check("expiry_active", 32'(active), 32'd0);

    // Drain life to zero, then confirm freeze and reset recovery.
    step(0, 1, 4'b1111, '0);
    ticks(16);
    step(0, 1, 4'b0011, '0);
    ticks(16);
    check("drained_go", 32'(game_over), 32'd1);
    check("drained_life", 32'(life), 32'd0);
    for (int i = 0; i < 40; i++) step(0, $urandom_range(0, 1), 4'($urandom), 4'($urandom));
    check("frozen_score", 32'(score), 32'd0);
    step(1, 1, '1, '1);
    check("recover_life", 32'(life), 32'h3FF);
    check("recover_go", 32'(game_over), 32'd0);

    // Randomised play, keys biased toward the hit window.
    for (int c = 0; c < 4000; c++) begin
      t  = ($urandom_range(0, 1) == 1);
      sp = '0; k = '0;
      for (int i = 0; i < LANES; i++) begin
        sp[i] = ($urandom_range(0, 3) == 0);
        d = m_pos[i] - HIT_POS;
        if (d < 0) d = -d;
        if (m_act[i] == 1 && d <= GOOD_WIN + 1) k[i] = ($urandom_range(0, 2) != 0);
        else k[i] = ($urandom_range(0, 15) == 0);
      end
      r = (m_go && $urandom_range(0, 9) == 0) || ($urandom_range(0, 499) == 0);
      step(r, t, sp, k);
    end

    // Saturation run: perfect hits only, tick every cycle.
    step(1, 0, '0, '0);
    saw_9998 = 0;
    for (int c = 0; c < 20000 && m_score < 9999; c++) begin
      sp = '0; k = '0;
      for (int i = 0; i < LANES; i++) begin
        sp[i] = (m_score < 9980) || (i == 0);
        k[i]  = (m_act[i] == 1 && m_pos[i] == HIT_POS);
      end
      if (m_score == 9998 && k[0]) saw_9998 = 1;
      step(0, 1, sp, k);
      if (saw_9998) begin
        check("sat_score_9999", 32'(score), 32'd9999);
        saw_9998 = 0;
      end
    end
    check("sat_score_final", 32'(score), 32'd9999);
    check("sat_combo", 32'(combo), 32'd255);
    check("sat_life", 32'(life), 32'h3FF);

    step(0, 0, '0, '0);
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_judge.md
LANE_JUDGE -- requirements
Module: lane_judge

Interface
REQ-001 Parameter LANES, default 4: number of independent note lanes, 1..8.
REQ-002 Parameter POS_W, default 4: note position width; POS_MAX = 2**POS_W-1.
REQ-003 Parameter HIT_POS, default 12: position of the hit zone; must be < POS_MAX.
REQ-004 Parameter GOOD_WIN, default 1: half-width of the GOOD window in positions.
REQ-005 Parameter LIFE_MAX, default 10: number of life units.
REQ-006 Port clk  in  1: single system clock; all logic on rising edge.
REQ-007 Port rst  in  1: reset, synchronous and active-high.
REQ-008 Port tick  in  1: one-cycle advance strobe, already synchronised to clk.
REQ-009 Port spawn  in  LANES: per-lane new-note request, sampled only on tick.
REQ-010 Port key  in  LANES: per-lane one-cycle key-press pulse.
REQ-011 Port pos  out  LANES*POS_W: per-lane note position; lane i at bits [i*POS_W +: POS_W].
REQ-012 Port active  out  LANES: per-lane note-present flag.
REQ-013 Port hit  out  1: one-cycle pulse, at least one lane judged GOOD or PERFECT.
REQ-014 Port perfect  out  1: one-cycle pulse, at least one lane judged PERFECT.
REQ-015 Port damage  out  1: one-cycle pulse, at least one note expired.
REQ-016 Port combo  out  8: consecutive-hit count.
REQ-017 Port score  out  14: accumulated score, 0..9999.
REQ-018 Port life  out  LIFE_MAX: thermometer code, bit k set while life > k.
REQ-019 Port game_over  out  1: level, set when life reaches 0.

Function
REQ-020 All outputs are registered; each effect appears on the cycle after the triggering input.
REQ-021 Each lane holds at most one note; lane state is {active, pos}.
REQ-022 On tick, an active lane with pos < POS_MAX increments pos by 1.
REQ-023 On tick, an active lane with pos == POS_MAX expires: active cleared, pos set to 0, miss counted.
REQ-024 On tick, spawn[i] with lane i inactive sets active=1, pos=0; spawn[i] into an active lane is ignored.
REQ-025 key[i] with lane i inactive is ignored, with no score, combo or life effect.
REQ-026 key[i] with lane active and pos == HIT_POS: PERFECT; lane cleared; score +2.
REQ-027 key[i] with lane active and 0 < |pos-HIT_POS| <= GOOD_WIN: GOOD; lane cleared; score +1.
REQ-028 key[i] with lane active and outside the window: off-beat miss; lane unchanged; combo cleared; no life loss.
REQ-029 Judging uses the pre-tick pos; a lane hit in the same cycle as tick is cleared and neither advances nor expires.
REQ-030 A lane that expires on a tick may accept a spawn on the same tick; the spawn wins and the lane becomes active at pos 0.
REQ-031 Multiple lanes in one cycle: score adds the sum of all lane awards; combo adds the number of hits; life drops by the number of expiries.
REQ-032 Score saturates at 9999; combo saturates at 255; life saturates at 0.
REQ-033 Any miss in a cycle (expiry or off-beat) sets combo to 0, even if other lanes hit in that cycle.
REQ-034 When life reaches 0, game_over is set and all state freezes; tick, spawn and key are ignored until rst.
REQ-035 Pulses hit, perfect and damage are high for exactly one cycle per event cycle and never stretch.

Reset
REQ-036 On rst: all active=0, all pos=0, score=0, combo=0, life all ones, game_over=0, all pulses 0.
REQ-037 rst dominates all other inputs in the same cycle, including mid-game and after game_over.

Verification
REQ-038 Spawn lane0, 12 ticks, key[0] -> perfect=1 and hit=1 for one cycle; score=2; combo=1; active[0]=0.
REQ-039 Spawn lane1, 11 ticks, key[1] -> GOOD: hit=1, perfect=0, score+1; key[1] at pos 5 -> combo=0, life unchanged, note stays.
REQ-040 Spawn all 4 lanes, 16 ticks, no keys -> on the 16th tick damage=1, life drops 10->6, combo=0, all active=0.
REQ-041 key[2] and tick in the same cycle with pos=12 -> PERFECT judged; lane cleared; no advance, no damage.
REQ-042 Drain life to 0 -> game_over=1; later spawns, ticks and keys change nothing; rst restores life=10'h3FF and game_over=0.
REQ-043 Preload score to 9998 and hit PERFECT -> score=9999; 256 consecutive hits -> combo holds at 255.
